mem_byte_seq: RTL
=================

Name: mem_byte_seq

Overview:
Initiator for the byte-wide 16 KB on-chip memory. Accepts one 32-bit word request at a time from the CPU/bus side with per-byte selects. Converts it into four sequential byte cycles on the memory's adr/dat/we/en interface and returns assembled read data with a one-cycle ack. Sits between the core's data/instruction port and the byte memory macro.

Parameters:
ADR_W, 14, byte address width; must match the memory depth, 2^14 bytes.
BIG_ENDIAN, 1, 1 maps byte offset 0 to dat[31:24]/sel[3] (OpenRISC order); 0 maps byte offset 0 to dat[7:0]/sel[0].

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-low (rst=0 at a rising edge resets).
req_i  in  1  access request; level, sampled only in IDLE.
we_i  in  1  1 = write, 0 = read; latched with req_i.
adr_i  in  ADR_W  byte address; bits [1:0] ignored, so the word base is {adr_i[ADR_W-1:2],2'b00}.
sel_i  in  4  byte-lane selects for the word.
dat_i  in  32  write data.
dat_o  out  32  read data; valid while ack_o=1 and held until the next read completes.
ack_o  out  1  one-cycle completion pulse.
busy_o  out  1  1 whenever the state is not IDLE.
mem_adr_o  out  ADR_W  byte address to memory.
mem_dat_o  out  8  byte write data to memory.
mem_dat_i  in  8  byte read data from memory; combinational from the memory's adr/en/we.
mem_we_o  out  1  memory write enable.
mem_en_o  out  1  memory enable.

Behaviour:
- States: IDLE, XFER, DONE.
- 2-bit byte index idx counts 0..3 in XFER.
- Latched registers: base, we, sel, wdata.
- Reset (rst=0): state=IDLE, idx=0, dat_o=0, ack_o=0, busy_o=0, mem_en_o=0, mem_we_o=0, mem_adr_o=0, mem_dat_o=0.
- IDLE, req_i=1 at an edge: latch adr_i/we_i/sel_i/dat_i and set idx=0.
  - If sel_i=0000, go to DONE, skipping memory cycles.
  - Otherwise go to XFER.
- XFER: one cycle per idx, always 4 cycles, giving fixed latency.
  - mem_adr_o = base+idx.
  - lane = idx when BIG_ENDIAN=0; lane = 3-idx when BIG_ENDIAN=1.
  - mem_en_o = sel[lane]; mem_we_o = we & sel[lane]; mem_dat_o = wdata byte at lane.
- Write: the memory commits the byte at the rising edge ending that XFER cycle.
- Read: at that edge, capture mem_dat_i into read-assembly byte[lane] if sel[lane]=1; unselected lanes read as 0.
- Leaving XFER: after idx=3, go to DONE.
- DONE: ack_o=1 for exactly one cycle.
  - For a read, dat_o = assembled word, which is registered and stable through DONE and after.
  - For a write, dat_o is unchanged.
  - Next state is IDLE.
- Latency: request accepted at edge N → XFER during cycles N+1..N+4 → ack_o high in cycle N+5 → IDLE in cycle N+6. With sel=0, ack_o is high in cycle N+1.
- Signal timing:
  - mem_* outputs and ack_o/busy_o are decoded from state registers only; there is no combinational path from req_i.
  - mem_en_o=0 in IDLE and DONE.
- Handshake:
  - req_i is ignored in XFER and DONE.
  - The requester drops req_i after seeing ack_o=1. If req_i is still high in the following IDLE cycle, a new access starts.
  - Back-to-back accesses have a minimum of 1 IDLE cycle between ack and the next accept.
- Address wrap: base+idx is ADR_W-bit modular. Because base is word-aligned, no wrap occurs within a word.
- Reset mid-access: at the edge with rst=0, go to IDLE with no ack.
  - Bytes already written stay in memory.
  - dat_o is cleared.
  - A pending read is discarded.

Test Plan:
- Full-word write then read (BIG_ENDIAN=1): write adr=0x0010, sel=1111, dat=0x11223344 → memory [0x10..0x13]=11,22,33,44; ack_o 5 cycles after accept. Read back the same address → dat_o=0x11223344 with ack_o.
- Partial write: preload 0x20..0x23 with 00. Write adr=0x0022 (bits [1:0] ignored), sel=0100, dat=0xAABBCCDD → only byte 0x21=BB; mem_en_o high for exactly one of the 4 XFER cycles.
- Partial read: with 0x30..0x33 = DE,AD,BE,EF, read sel=0011 → dat_o=0x0000BEEF. Then read sel=1000 → dat_o=0xDE000000.
- Null select: req with sel=0000 → ack_o in the cycle after accept; mem_en_o never asserted; dat_o unchanged for a write, 0 for a read.
- Reset mid-access: start a write sel=1111 to 0x40, dat=0x01020304, and assert rst=0 during the 3rd XFER cycle → 0x40=01 and 0x41=02 are written, 0x42/0x43 are untouched, no ack_o. Next cycle: busy_o=0, mem_en_o=0, dat_o=0.
- BIG_ENDIAN=0 build: write 0x11223344 sel=1111 to 0x50 → bytes 0x50..0x53 = 44,33,22,11; read back → 0x11223344. Held req_i after ack → second access starts after exactly one IDLE cycle.

Source files
------------

// File: rtl/mem_byte_seq.sv
// Word-to-byte sequencer: turns one 32-bit request with byte selects into four
// fixed byte cycles on a byte-wide memory, then acks with the assembled read word.
module mem_byte_seq #(
    parameter int ADR_W      = 14,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [ADR_W-1:0] adr_i,
    input  logic [3:0]       sel_i,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    output logic             ack_o,
    output logic             busy_o,
    output logic [ADR_W-1:0] mem_adr_o,
    output logic [7:0]       mem_dat_o,
    input  logic [7:0]       mem_dat_i,
    output logic             mem_we_o,
    output logic             mem_en_o
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         idx_reg;
    logic [ADR_W-1:0]   base_reg;
    logic               we_reg;
    logic [3:0]         sel_reg;
    logic [31:0]        wdata_reg;
    logic [31:0]        rdata_reg, rdata_next;
    logic [31:0]        dat_reg;
    logic [1:0]         lane;
    logic               lane_sel;

    // Byte offset 0 lands on the most significant lane in big-endian builds.
    assign lane     = BIG_ENDIAN ? ~idx_reg : idx_reg;
    assign lane_sel = sel_reg[lane];

    logic unused_adr_bits;
    assign unused_adr_bits = ^adr_i[1:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rdata_next[8*gi +: 8] =
                (state_reg == XFER && lane_sel && lane == 2'(gi)) ? mem_dat_i
                                                                  : rdata_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ack_o      = 1'b0;
        busy_o     = (state_reg != IDLE);
        mem_adr_o  = '0;
        mem_dat_o  = '0;
        mem_en_o   = 1'b0;
        mem_we_o   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_i)
                    state_next = (sel_i == 4'b0000) ? DONE : XFER;
            end
            XFER: begin
                mem_adr_o = base_reg + ADR_W'(idx_reg);
                mem_dat_o = wdata_reg[{lane, 3'b000} +: 8];
                // A cycle that ends in reset must not commit its byte.
                mem_en_o  = lane_sel & rst;
                mem_we_o  = we_reg & lane_sel & rst;
                if (idx_reg == 2'd3)
                    state_next = DONE;
            end
            DONE: begin
                ack_o      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            base_reg  <= '0;
            we_reg    <= 1'b0;
            sel_reg   <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            dat_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_i) begin
                        base_reg  <= {adr_i[ADR_W-1:2], 2'b00};
                        we_reg    <= we_i;
                        sel_reg   <= sel_i;
                        wdata_reg <= dat_i;
                        idx_reg   <= '0;
                        rdata_reg <= '0;
                        if (sel_i == 4'b0000 && !we_i)
                            dat_reg <= '0;
                    end
                end
                XFER: begin
                    idx_reg   <= idx_reg + 2'd1;
                    rdata_reg <= rdata_next;
                    // Publish the word on the same edge that captures the last byte.
                    if (idx_reg == 2'd3 && !we_reg)
                        dat_reg <= rdata_next;
                end
                default: ;
            endcase
        end
    end

    assign dat_o = dat_reg;

endmodule
